spi_master_cfg: RTL
===================

// Module: spi_master_cfg
// PURPOSE
//  Parametrised full-duplex SPI master with configurable word width, clock divider, mode and chip-select count.
//  Successor to the fixed 12-bit LSB-first transmitter: adds MISO capture, all four CPOL/CPHA modes and a valid/ready request port.
//  SCLK is generated from a clk-enable counter; nothing in the block is clocked by SCLK.
//  Sits between a host register/command block and off-chip SPI peripherals (DACs, ADCs, flash).
// PARAMETERS
//  DATA_W     12  bits per transfer (>=2)
//  CLK_DIV    50  clk cycles per SCLK half-period (>=1)
//  NUM_CS     1   number of chip-select lines (>=1)
//  LSB_FIRST  1   1: bit 0 shifted first; 0: bit DATA_W-1 first (applies to TX and RX)
// PORTS
//  clk       in   1                 system clock
//  rst_n     in   1                 synchronous reset, active-low
//  tx_valid  in   1                 transfer request
//  tx_ready  out  1                 high in IDLE only; request accepted when tx_valid & tx_ready at posedge clk
//  din       in   DATA_W            TX word, latched on accept
//  cs_sel    in   $clog2(NUM_CS)+1  target chip select, latched on accept
//  mode      in   2                 {CPOL,CPHA}, latched on accept
//  busy      out  1                 high from accept until return to IDLE
//  rx_data   out  DATA_W            last received word, held until next rx_valid
//  rx_valid  out  1                 one-cycle pulse when rx_data updates
//  sclk      out  1                 SPI clock
//  cs_n      out  NUM_CS            active-low chip selects
//  mosi      out  1                 serial data out
//  miso      in   1                 serial data in
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, sclk=0, cs_n=all 1, mosi=0, rx_data=0, rx_valid=0, busy=0, tx_ready=1 after release.
//  Reset mid-transfer aborts immediately: no rx_valid; outputs take reset values the next cycle.
//  States: IDLE -> LEAD -> XFER -> TRAIL -> IDLE.
//  IDLE: sclk=latched CPOL (last transfer's CPOL; 0 after reset); cs_n all 1; mosi=0.
//  Accept (IDLE & tx_valid): latch din, cs_sel, mode; half-period counter=0; go LEAD.
//   cs_n[cs_sel]=0 on that edge; sclk=new CPOL on that edge.
//  cs_sel>=NUM_CS: transfer runs normally, all cs_n stay 1, rx_valid still pulses.
//  LEAD: CLK_DIV cycles (CS setup). CPHA=0: mosi=first bit from accept edge.
//  XFER: 2*DATA_W SCLK edges, one every CLK_DIV cycles; edges numbered 1..2*DATA_W.
//   Odd edges are leading (sclk leaves CPOL); even edges are trailing.
//   CPHA=0: sample miso on odd edges; drive next bit on even edges except edge 2*DATA_W.
//   CPHA=1: drive bit on odd edges; sample miso on even edges.
//   After edge 2*DATA_W, sclk=CPOL again.
//  TRAIL: CLK_DIV cycles (CS hold); then go IDLE.
//   On exit: cs_n all 1; mosi=0; rx_data=shift reg; rx_valid=1 for one cycle.
//  Latency: accept edge to rx_valid = CLK_DIV*(2*DATA_W+2) clk cycles.
//  tx_ready is 1 in the rx_valid cycle; back-to-back requests give CS high for at least 1 clk between words.
//  tx_valid, din, cs_sel and mode are ignored while busy.
//  Divider: a counter 0..CLK_DIV-1 fires a tick at CLK_DIV-1; it is cleared on accept and held at 0 in IDLE.
// TESTING
//  T1 DATA_W=8,CLK_DIV=2,LSB_FIRST=0, mode 0, din=8'hA5, miso tied to mosi
//     -> 8 rising edges; mosi bits 1,0,1,0,0,1,0,1; rx_data=8'hA5; rx_valid exactly 36 clk after accept.
//  T2 same config, mode 3, din=8'h3C, miso driven 8'hC3 by a mode-3 slave model
//     -> sclk idles 1; rx_data=8'hC3; sclk=1 while cs_n low before edge 1 and after edge 16.
//  T3 LSB_FIRST=1, DATA_W=12, mode 1, din=12'h801
//     -> mosi sequence 1,0,...,0,1; rx_data matches slave-model word.
//  T4 NUM_CS=4: cs_sel=2 -> only cs_n[2] low. cs_sel=5 -> cs_n stays 4'hF; rx_valid still pulses.
//  T5 tx_valid held high with two words -> second accepted in first word's rx_valid cycle; cs_n high >=1 clk between words.
//  T6 rst_n low at edge 5 of a transfer -> next cycle cs_n all 1, sclk=0, mosi=0; no rx_valid; tx_ready=1 after release.

Source files
------------

// File: rtl/spi_master_cfg.sv
// spi_master_cfg: full-duplex SPI master with a configurable word width,
// SCLK divider, CPOL/CPHA mode, chip-select count and bit order.
// Everything runs on clk; SCLK is a register toggled on divider ticks.
// A transfer is IDLE -> LEAD (CS setup) -> XFER (2*DATA_W SCLK edges)
// -> TRAIL (CS hold) -> IDLE, and the received word is published with
// a one-cycle rx_valid pulse on the way back to IDLE.

module spi_master_cfg #(
    parameter int DATA_W    = 12,
    parameter int CLK_DIV   = 50,
    parameter int NUM_CS    = 1,
    parameter int LSB_FIRST = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    input  logic [DATA_W-1:0]       din,
    input  logic [$clog2(NUM_CS):0] cs_sel,
    input  logic [1:0]              mode,
    output logic                    busy,
    output logic [DATA_W-1:0]       rx_data,
    output logic                    rx_valid,
    output logic                    sclk,
    output logic [NUM_CS-1:0]       cs_n,
    output logic                    mosi,
    input  logic                    miso
);

    // Widths of the chip-select index, half-period counter and edge counter.
    localparam int CS_W   = $clog2(NUM_CS) + 1;
    localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W);

    // Transfer phases.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LEAD  = 2'd1;
    localparam logic [1:0] S_XFER  = 2'd2;
    localparam logic [1:0] S_TRAIL = 2'd3;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [EDGE_W-1:0] r_edge;
    logic              r_sclk;
    logic              r_mosi;
    logic              r_cpol;
    logic              r_cpha;
    logic [DATA_W-1:0] r_tx_shift;
    logic [DATA_W-1:0] r_rx_shift;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic [NUM_CS-1:0] r_cs_n;

    logic              w_idle;
    logic              w_accept;
    logic              w_tick;
    logic              w_xfer_tick;
    logic              w_trail_done;
    logic [EDGE_W-1:0] w_edge_num;
    logic              w_leading;
    logic              w_last_edge;
    logic              w_din_head;
    logic [DATA_W-1:0] w_din_next;
    logic              w_tx_head;
    logic [DATA_W-1:0] w_tx_next;
    logic [DATA_W-1:0] w_rx_next;
    logic [NUM_CS-1:0] w_cs_dec;

    assign w_idle       = (r_state == S_IDLE);
    assign w_accept     = w_idle && tx_valid;
    // The divider only runs outside IDLE, so a tick never fires while idle.
    assign w_tick       = !w_idle && (r_cnt == CNT_LAST);
    assign w_xfer_tick  = (r_state == S_XFER) && w_tick;
    assign w_trail_done = (r_state == S_TRAIL) && w_tick;

    // Edge about to be produced on this tick, numbered from 1; odd = leading.
    assign w_edge_num  = r_edge + EDGE_W'(1);
    assign w_leading   = w_edge_num[0];
    assign w_last_edge = (w_edge_num == EDGE_LAST);

    // Bit-order dependent views of the shift registers. The TX shifter
    // always presents the next bit to send at its head; the RX shifter
    // fills so that the first sampled bit ends up at the first-sent position.
    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign w_din_head = din[0];
            assign w_din_next = {1'b0, din[DATA_W-1:1]};
            assign w_tx_head  = r_tx_shift[0];
            assign w_tx_next  = {1'b0, r_tx_shift[DATA_W-1:1]};
            assign w_rx_next  = {miso, r_rx_shift[DATA_W-1:1]};
        end else begin : g_msb_first
            assign w_din_head = din[DATA_W-1];
            assign w_din_next = {din[DATA_W-2:0], 1'b0};
            assign w_tx_head  = r_tx_shift[DATA_W-1];
            assign w_tx_next  = {r_tx_shift[DATA_W-2:0], 1'b0};
            assign w_rx_next  = {r_rx_shift[DATA_W-2:0], miso};
        end
    endgenerate

    // One decoder bit per chip select; an out-of-range cs_sel matches none,
    // so the transfer still runs with every chip select left high.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
            assign w_cs_dec[gi] = (cs_sel == CS_W'(gi));
        end
    endgenerate

    // Half-period counter: held at 0 in IDLE, restarted on accept, wraps on tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_idle || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Phase sequencing and SCLK edge count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_edge  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (tx_valid) begin
                        r_state <= S_LEAD;
                        r_edge  <= '0;
                    end
                end
                S_LEAD: begin
                    if (w_tick) begin
                        r_state <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (w_tick) begin
                        r_edge <= w_edge_num;
                        if (w_last_edge) begin
                            r_state <= S_TRAIL;
                        end
                    end
                end
                S_TRAIL: begin
                    if (w_tick) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // SCLK generation, MOSI drive and MISO capture on leading/trailing edges.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
        end else if (w_accept) begin
            r_cpol     <= mode[1];
            r_cpha     <= mode[0];
            r_sclk     <= mode[1];
            r_rx_shift <= '0;
            if (!mode[0]) begin
                // CPHA=0: first bit must be on the wire before the first edge.
                r_mosi     <= w_din_head;
                r_tx_shift <= w_din_next;
            end else begin
                r_mosi     <= 1'b0;
                r_tx_shift <= din;
            end
        end else if (w_xfer_tick) begin
            if (w_leading) begin
                r_sclk <= ~r_cpol;
                if (r_cpha) begin
                    r_mosi     <= w_tx_head;
                    r_tx_shift <= w_tx_next;
                end else begin
                    r_rx_shift <= w_rx_next;
                end
            end else begin
                r_sclk <= r_cpol;
                if (r_cpha) begin
                    r_rx_shift <= w_rx_next;
                end else if (!w_last_edge) begin
                    // The final trailing edge has no following bit to present.
                    r_mosi     <= w_tx_head;
                    r_tx_shift <= w_tx_next;
                end
            end
        end else if (w_trail_done) begin
            r_mosi <= 1'b0;
        end
    end

    // Chip selects: asserted on accept, released when the hold time ends.
    generate
        for (gi = 0; gi < NUM_CS; gi++) begin : g_cs_reg
            // Per-line chip-select register.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_cs_n[gi] <= 1'b1;
                end else if (w_accept) begin
                    r_cs_n[gi] <= ~w_cs_dec[gi];
                end else if (w_trail_done) begin
                    r_cs_n[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    // Publish the received word with a single-cycle valid on return to IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= w_trail_done;
            if (w_trail_done) begin
                r_rx_data <= r_rx_shift;
            end
        end
    end

    assign tx_ready = w_idle;
    assign busy     = !w_idle;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign sclk     = r_sclk;
    assign cs_n     = r_cs_n;
    assign mosi     = r_mosi;

endmodule
